coin_credit_engine: RTL and testbench

- Parametrised next-generation coin credit block for the vending machine datapath.
- Accepts N coin channels with per-channel values and accumulates credit with a saturation guard.
- Services vend requests against a price input, and returns change coin-by-coin through a ready-gated change FSM.
- Sits between the coin acceptor front end and the product/dispense controller.

---
 rtl/coin_credit_engine.sv | 185 ++++++++++++++++++
 tb/tb_coin_credit_engine.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/coin_credit_engine.sv
// Coin credit engine: accumulates coin credit, services vend/refund requests and
// returns change coin-by-coin. Optional idle auto-refund under CREDIT_TIMEOUT_EN.
module coin_credit_engine #(
  parameter int                         NUM_COINS      = 3,
  parameter logic [8*NUM_COINS-1:0]     COIN_VALUES    = 24'h190A05,
  parameter int                         CREDIT_W       = 10,
  parameter int                         MAX_CREDIT     = 1000,
  parameter int                         TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic                 vend_req,
  input  logic [CREDIT_W-1:0]  price,
  input  logic                 refund_req,
  input  logic                 change_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 vend_ok,
  output logic                 vend_deny,
  output logic                 coin_reject,
  output logic [NUM_COINS-1:0] change_out,
  output logic                 change_done,
  output logic                 busy
);

  localparam int SW = CREDIT_W + 2;

  typedef enum logic {IDLE = 1'b0, CHANGE = 1'b1} state_t;

  state_t               state_r;
  logic [CREDIT_W-1:0]  credit_r;
  logic                 vend_ok_r;
  logic                 vend_deny_r;
  logic                 coin_reject_r;
  logic [NUM_COINS-1:0] change_out_r;
  logic                 change_done_r;
  logic                 busy_r;

  logic [SW-1:0]        credit_ext_s;
  logic [SW-1:0]        sum_s;
  logic [SW-1:0]        total_s;
  logic                 fits_s;
  logic                 pick_any_s;
  logic [NUM_COINS-1:0] pick_onehot_s;
  logic [SW-1:0]        pick_val_s;

`ifdef CREDIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_r;
  logic          idle_s;
`endif

  function automatic logic [SW-1:0] coin_val(input int idx);
    return SW'(COIN_VALUES[8*idx +: 8]);
  endfunction

  // Coin sum, overflow guard and largest-coin selection for change return
  always_comb begin
    credit_ext_s  = SW'(credit_r);
    sum_s         = {SW{1'b0}};
    pick_any_s    = 1'b0;
    pick_onehot_s = {NUM_COINS{1'b0}};
    pick_val_s    = {SW{1'b0}};
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin_in[i]) begin
        sum_s = sum_s + coin_val(i);
      end else begin
        sum_s = sum_s;
      end
      // Values ascend with index, so the last match is the largest coin that fits.
      if (coin_val(i) <= credit_ext_s) begin
        pick_any_s       = 1'b1;
        pick_onehot_s    = {NUM_COINS{1'b0}};
        pick_onehot_s[i] = 1'b1;
        pick_val_s       = coin_val(i);
      end else begin
        pick_any_s = pick_any_s;
      end
    end
    total_s = credit_ext_s + sum_s;
    fits_s  = (total_s <= SW'(MAX_CREDIT));
  end

`ifdef CREDIT_TIMEOUT_EN
  assign idle_s = (state_r == IDLE) && (credit_r != {CREDIT_W{1'b0}}) &&
                  !(|coin_in) && !vend_req && !refund_req;
`endif

  // Control FSM with registered credit and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      credit_r      <= {CREDIT_W{1'b0}};
      vend_ok_r     <= 1'b0;
      vend_deny_r   <= 1'b0;
      coin_reject_r <= 1'b0;
      change_out_r  <= {NUM_COINS{1'b0}};
      change_done_r <= 1'b0;
      busy_r        <= 1'b0;
`ifdef CREDIT_TIMEOUT_EN
      idle_cnt_r    <= {TW{1'b0}};
`endif
    end else begin
      vend_ok_r     <= 1'b0;
      vend_deny_r   <= 1'b0;
      coin_reject_r <= 1'b0;
      change_out_r  <= {NUM_COINS{1'b0}};
      change_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (refund_req) begin
            coin_reject_r <= |coin_in;
            if (credit_r != {CREDIT_W{1'b0}}) begin
              state_r <= CHANGE;
              busy_r  <= 1'b1;
            end else begin
              change_done_r <= 1'b1;
            end
          end else if (vend_req) begin
            coin_reject_r <= |coin_in;
            if (credit_r >= price) begin
              credit_r  <= credit_r - price;
              vend_ok_r <= 1'b1;
            end else begin
              vend_deny_r <= 1'b1;
            end
          end else if (|coin_in) begin
            if (fits_s) begin
              credit_r <= CREDIT_W'(total_s);
            end else begin
              coin_reject_r <= 1'b1;
            end
          end else begin
`ifdef CREDIT_TIMEOUT_EN
            if (idle_s && (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1))) begin
              state_r <= CHANGE;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
`else
            state_r <= IDLE;
`endif
          end
        end
        CHANGE: begin
          coin_reject_r <= |coin_in;
          vend_deny_r   <= vend_req;
          // Exit is not gated by change_ready: no coin is dispensed on this cycle.
          if (!pick_any_s) begin
            credit_r      <= {CREDIT_W{1'b0}};
            change_done_r <= 1'b1;
            state_r       <= IDLE;
            busy_r        <= 1'b0;
          end else if (change_ready) begin
            change_out_r <= pick_onehot_s;
            credit_r     <= CREDIT_W'(credit_ext_s - pick_val_s);
          end else begin
            credit_r <= credit_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
`ifdef CREDIT_TIMEOUT_EN
      if (idle_s && (idle_cnt_r != TW'(TIMEOUT_CYCLES - 1))) begin
        idle_cnt_r <= idle_cnt_r + TW'(1);
      end else begin
        idle_cnt_r <= {TW{1'b0}};
      end
`endif
    end
  end

  assign credit      = credit_r;
  assign vend_ok     = vend_ok_r;
  assign vend_deny   = vend_deny_r;
  assign coin_reject = coin_reject_r;
  assign change_out  = change_out_r;
  assign change_done = change_done_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_coin_credit_engine.sv
// Table-driven scoreboard bench for coin_credit_engine (default coin values 5/10/25).
module tb_coin_credit_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] coin_in;
  logic       vend_req;
  logic [9:0] price;
  logic       refund_req;
  logic       change_ready;
  logic [9:0] credit;
  logic       vend_ok;
  logic       vend_deny;
  logic       coin_reject;
  logic [2:0] change_out;
  logic       change_done;
  logic       busy;

  always #5 clk = ~clk;

  coin_credit_engine #(
    .NUM_COINS(3), .COIN_VALUES(24'h190A05), .CREDIT_W(10),
    .MAX_CREDIT(1000), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .vend_req(vend_req), .price(price),
    .refund_req(refund_req), .change_ready(change_ready), .credit(credit),
    .vend_ok(vend_ok), .vend_deny(vend_deny), .coin_reject(coin_reject),
    .change_out(change_out), .change_done(change_done), .busy(busy)
  );

  typedef struct {
    string      name;
    logic [2:0] coin;
    logic       vend;
    logic [9:0] price;
    logic       refund;
    logic       ready;
    logic [9:0] e_credit;
    logic       e_ok;
    logic       e_deny;
    logic       e_rej;
    logic [2:0] e_chg;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  vec_t        tbl[$];
  logic [17:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          passed = 0;

  function automatic vec_t mk(string n, logic [2:0] c, logic v, logic [9:0] p, logic r,
                              logic rdy, logic [9:0] ec, logic ok, logic dn, logic rj,
                              logic [2:0] chg, logic dne, logic bsy);
    vec_t t;
    t.name = n; t.coin = c; t.vend = v; t.price = p; t.refund = r; t.ready = rdy;
    t.e_credit = ec; t.e_ok = ok; t.e_deny = dn; t.e_rej = rj; t.e_chg = chg;
    t.e_done = dne; t.e_busy = bsy;
    return t;
  endfunction

  // Drive one vector, queue its expectation, then compare one edge later.
  task automatic step(input vec_t v);
    logic [17:0] got;
    logic [17:0] e;
    string       n;
    coin_in = v.coin; vend_req = v.vend; price = v.price;
    refund_req = v.refund; change_ready = v.ready;
    exp_q.push_back({v.e_credit, v.e_ok, v.e_deny, v.e_rej, v.e_chg, v.e_done, v.e_busy});
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    got = {credit, vend_ok, vend_deny, coin_reject, change_out, change_done, busy};
    e = exp_q.pop_front();
    n = name_q.pop_front();
    checks++;
    if (got === e) begin
      passed++;
    end else begin
      $display("FAIL %s: got credit=%0d ok=%b deny=%b rej=%b chg=%b done=%b busy=%b, want credit=%0d ok=%b deny=%b rej=%b chg=%b done=%b busy=%b",
               n, got[17:8], got[7], got[6], got[5], got[4:2], got[1], got[0],
               e[17:8], e[7], e[6], e[5], e[4:2], e[1], e[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    coin_in = 3'b000; vend_req = 1'b0; price = 10'd0; refund_req = 1'b0; change_ready = 1'b1;
    @(posedge clk); #1;
    step(mk("reset", 3'b000, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    rst = 1'b0;

    // Main sequence: coins, vends, refund with stall, change return
    tbl.push_back(mk("nickel",      3'b001, 1'b0, 10'd0,  1'b0, 1'b1, 10'd5,  1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("dime",        3'b010, 1'b0, 10'd0,  1'b0, 1'b1, 10'd15, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("quarter",     3'b100, 1'b0, 10'd0,  1'b0, 1'b1, 10'd40, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("vend35",      3'b000, 1'b1, 10'd35, 1'b0, 1'b1, 10'd5,  1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("vend10_deny", 3'b000, 1'b1, 10'd10, 1'b0, 1'b1, 10'd5,  1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("vend5_coin",  3'b100, 1'b1, 10'd5,  1'b0, 1'b1, 10'd0,  1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("vend0_at0",   3'b000, 1'b1, 10'd0,  1'b0, 1'b1, 10'd0,  1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("all_coins",   3'b111, 1'b0, 10'd0,  1'b0, 1'b1, 10'd40, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("to65",        3'b100, 1'b0, 10'd0,  1'b0, 1'b1, 10'd65, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("refund65",    3'b000, 1'b0, 10'd0,  1'b1, 1'b1, 10'd65, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1));
    tbl.push_back(mk("chg_q1",      3'b000, 1'b0, 10'd0,  1'b0, 1'b1, 10'd40, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1));
    tbl.push_back(mk("stall_coin",  3'b100, 1'b0, 10'd0,  1'b0, 1'b0, 10'd40, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1));
    tbl.push_back(mk("stall_vend",  3'b000, 1'b1, 10'd5,  1'b0, 1'b0, 10'd40, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1));
    tbl.push_back(mk("chg_q2",      3'b000, 1'b0, 10'd0,  1'b0, 1'b1, 10'd15, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1));
    tbl.push_back(mk("chg_dime",    3'b000, 1'b0, 10'd0,  1'b0, 1'b1, 10'd5,  1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1));
    tbl.push_back(mk("chg_nick_rf", 3'b000, 1'b0, 10'd0,  1'b1, 1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1));
    tbl.push_back(mk("chg_done",    3'b000, 1'b0, 10'd0,  1'b0, 1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0));
    tbl.push_back(mk("refund_at0",  3'b010, 1'b0, 10'd0,  1'b1, 1'b1, 10'd0,  1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0));
    tbl.push_back(mk("idle0",       3'b000, 1'b0, 10'd0,  1'b0, 1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    // Saturation guard: build 990 then probe the MAX_CREDIT boundary
    for (int k = 1; k <= 39; k++) begin
      tbl.push_back(mk("fill_q", 3'b100, 1'b0, 10'd0, 1'b0, 1'b1, 10'(25 * k), 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    end
    tbl.push_back(mk("to990",       3'b011, 1'b0, 10'd0,  1'b0, 1'b1, 10'd990,  1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("ovf_quarter", 3'b100, 1'b0, 10'd0,  1'b0, 1'b1, 10'd990,  1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("to995",       3'b001, 1'b0, 10'd0,  1'b0, 1'b1, 10'd995,  1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("ovf_011",     3'b011, 1'b0, 10'd0,  1'b0, 1'b1, 10'd995,  1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("exact_max",   3'b001, 1'b0, 10'd0,  1'b0, 1'b1, 10'd1000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    tbl.push_back(mk("ovf_at_max",  3'b001, 1'b0, 10'd0,  1'b0, 1'b1, 10'd1000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Reset while returning change
    rst = 1'b1;
    step(mk("rst_clr", 3'b000, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    rst = 1'b0;
    step(mk("r_coins",  3'b111, 1'b0, 10'd0, 1'b0, 1'b1, 10'd40, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    step(mk("r_refund", 3'b000, 1'b0, 10'd0, 1'b1, 1'b1, 10'd40, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1));
    rst = 1'b1;
    step(mk("rst_midchg", 3'b000, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    rst = 1'b0;

    // Idle credit: auto-refund after 8 idle cycles only when the timeout is built
    step(mk("t_dime", 3'b010, 1'b0, 10'd0, 1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    for (int k = 1; k <= 7; k++) begin
      step(mk("t_idle", 3'b000, 1'b0, 10'd0, 1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    end
`ifdef CREDIT_TIMEOUT_EN
    step(mk("t_enter", 3'b000, 1'b0, 10'd0, 1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1));
    step(mk("t_chg",   3'b000, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1));
    step(mk("t_done",  3'b000, 1'b0, 10'd0, 1'b0, 1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0));
`else
    for (int k = 0; k < 4; k++) begin
      step(mk("t_hold", 3'b000, 1'b0, 10'd0, 1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
